// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the register bank write port, one entry per cycle,
// with two combinational bypass lookups over the entries still waiting to be written.
module reg_writeback_queue #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int DISCARD_R0 = 1,
    parameter int PTR_W      = $clog2(DEPTH),
    parameter int CNT_W      = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              hold,
    input  logic              flush,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              RegWrite,
    input  logic [ADDR_W-1:0] lk_addr_1,
    output logic              lk_hit_1,
    output logic [DATA_W-1:0] lk_data_1,
    input  logic [ADDR_W-1:0] lk_addr_2,
    output logic              lk_hit_2,
    output logic [DATA_W-1:0] lk_data_2,
    output logic [CNT_W-1:0]  count
);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_store;
    logic              w_pop;
    logic              w_nonempty;
    logic              w_r0_req;
    logic              w_hit_1;
    logic              w_hit_2;
    logic [DATA_W-1:0] w_data_1;
    logic [DATA_W-1:0] w_data_2;
    logic [PTR_W-1:0]  w_idx;
    logic              w_m1;
    logic              w_m2;

    assign w_nonempty = (r_count != {CNT_W{1'b0}});
    assign in_ready   = (r_count != CNT_W'(DEPTH)) & ~flush;
    assign w_push     = in_valid & in_ready;
    assign w_r0_req   = (DISCARD_R0 != 0) && (in_addr == {ADDR_W{1'b0}});
    // A request to r0 still completes its handshake but is never queued.
    assign w_store    = w_push & ~w_r0_req;
    assign w_pop      = w_nonempty & ~hold & ~flush;

    assign RegWrite   = w_pop;
    assign write_addr = w_nonempty ? r_addr[r_rd_ptr] : {ADDR_W{1'b0}};
    assign write_data = w_nonempty ? r_data[r_rd_ptr] : {DATA_W{1'b0}};
    assign count      = r_count;

    // Bypass search from oldest to youngest so the youngest match is the one that sticks.
    always_comb begin
        w_hit_1  = 1'b0;
        w_hit_2  = 1'b0;
        w_data_1 = {DATA_W{1'b0}};
        w_data_2 = {DATA_W{1'b0}};
        w_idx    = {PTR_W{1'b0}};
        w_m1     = 1'b0;
        w_m2     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx    = r_rd_ptr + PTR_W'(i);
            w_m1     = (CNT_W'(i) < r_count) && (r_addr[w_idx] == lk_addr_1) &&
                       !((DISCARD_R0 != 0) && (lk_addr_1 == {ADDR_W{1'b0}}));
            w_m2     = (CNT_W'(i) < r_count) && (r_addr[w_idx] == lk_addr_2) &&
                       !((DISCARD_R0 != 0) && (lk_addr_2 == {ADDR_W{1'b0}}));
            w_hit_1  = w_hit_1 | w_m1;
            w_hit_2  = w_hit_2 | w_m2;
            w_data_1 = w_m1 ? r_data[w_idx] : w_data_1;
            w_data_2 = w_m2 ? r_data[w_idx] : w_data_2;
        end
    end

    assign lk_hit_1  = w_hit_1;
    assign lk_data_1 = w_data_1;
    assign lk_hit_2  = w_hit_2;
    assign lk_data_2 = w_data_2;

    // Pointer and occupancy bookkeeping; flush wins over any same-cycle push or pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            r_wr_ptr <= w_store ? r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1} : r_wr_ptr;
            r_rd_ptr <= w_pop   ? r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1} : r_rd_ptr;
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; slots beyond the occupancy count are never observed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= {ADDR_W{1'b0}};
                r_data[i] <= {DATA_W{1'b0}};
            end
        end else if (w_store) begin
            r_addr[r_wr_ptr] <= in_addr;
            r_data[r_wr_ptr] <= in_data;
        end else begin
            r_addr[r_wr_ptr] <= r_addr[r_wr_ptr];
            r_data[r_wr_ptr] <= r_data[r_wr_ptr];
        end
    end

endmodule
